// File: rtl/banner_sequencer.sv
// Round-robin scheduler for the single on-screen text banner: grant, hold, blank gap, ack.
// Optional BANNER_SKIP_EN adds a skip input that ends the visible banner early.
module banner_sequencer #(
    parameter int NUM_REQ     = 4,
    parameter int MSG_W       = 3,
    parameter int HOLD_CYCLES = 100000000,
    parameter int GAP_CYCLES  = 2,
    parameter int CNT_W       = 27
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_REQ-1:0]          req,
    input  logic [NUM_REQ*MSG_W-1:0]    msg_in,
    input  logic                        pause,
`ifdef BANNER_SKIP_EN
    input  logic                        skip,
`endif
    output logic [NUM_REQ-1:0]          ack,
    output logic                        show,
    output logic [MSG_W-1:0]            show_msg,
    output logic [$clog2(NUM_REQ)-1:0]  show_owner,
    output logic                        busy
);

    localparam int OW = $clog2(NUM_REQ);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_SHOW = 2'd1;
    localparam logic [1:0] S_GAP  = 2'd2;

    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

    logic [1:0]         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [OW-1:0]      rr_q, rr_d;
    logic [OW-1:0]      owner_q, owner_d;
    logic [MSG_W-1:0]   msg_q, msg_d;
    logic               show_q, show_d;
    logic               busy_q, busy_d;
    logic [NUM_REQ-1:0] ack_q, ack_d;

    logic               skip_w;
    logic               gnt_vld;
    logic [OW-1:0]      gnt_idx;
    logic [OW-1:0]      rr_next;
    int                 arb_j;
    logic [OW-1:0]      arb_idx;

`ifdef BANNER_SKIP_EN
    assign skip_w = skip;
`else
    assign skip_w = 1'b0;
`endif

    // Scan from the highest offset down so the lowest offset from rr_q wins.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_idx = '0;
        arb_j   = 0;
        arb_idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            arb_j = int'(rr_q) + k;
            if (arb_j >= NUM_REQ) arb_j = arb_j - NUM_REQ;
            arb_idx = OW'(arb_j);
            if (req[arb_idx]) begin
                gnt_vld = 1'b1;
                gnt_idx = arb_idx;
            end
        end
    end

    assign rr_next = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        msg_d   = msg_q;
        show_d  = show_q;
        ack_d   = '0;
        case (state_q)
            S_IDLE: begin
                if (gnt_vld) begin
                    state_d = S_SHOW;
                    cnt_d   = '0;
                    owner_d = gnt_idx;
                    msg_d   = msg_in[int'(gnt_idx)*MSG_W +: MSG_W];
                    show_d  = 1'b1;
                end
            end
            S_SHOW: begin
                // A dropped request takes precedence: the banner is abandoned without an ack.
                if (!req[owner_q]) begin
                    state_d = S_GAP;
                    cnt_d   = '0;
                    show_d  = 1'b0;
                    msg_d   = '0;
                    rr_d    = rr_next;
                end else if (skip_w || (cnt_q == HOLD_LAST && !pause)) begin
                    state_d        = S_GAP;
                    cnt_d          = '0;
                    show_d         = 1'b0;
                    msg_d          = '0;
                    rr_d           = rr_next;
                    ack_d[owner_q] = 1'b1;
                end else if (!pause) begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_GAP: begin
                if (!pause) begin
                    if (cnt_q == GAP_LAST) begin
                        state_d = S_IDLE;
                        cnt_d   = '0;
                        owner_d = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
                owner_d = '0;
                msg_d   = '0;
                show_d  = 1'b0;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            rr_q    <= '0;
            owner_q <= '0;
            msg_q   <= '0;
            show_q  <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            msg_q   <= msg_d;
            show_q  <= show_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
        end
    end

    assign ack        = ack_q;
    assign show       = show_q;
    assign show_msg   = msg_q;
    assign show_owner = owner_q;
    assign busy       = busy_q;

endmodule

// File: tb/tb_banner_sequencer.sv
// Scoreboard bench for banner_sequencer: expected banners queued at stimulus, checked as each banner ends.
module tb_banner_sequencer;

    localparam int NUM_REQ = 4;
    localparam int MSG_W   = 3;
    localparam int HOLD    = 8;
    localparam int GAP     = 2;

    logic                     clk = 1'b0;
    logic                     reset;
    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*MSG_W-1:0] msg_in;
    logic                     pause;
`ifdef BANNER_SKIP_EN
    logic                     skip;
`endif
    logic [NUM_REQ-1:0]       ack;
    logic                     show;
    logic [MSG_W-1:0]         show_msg;
    logic [1:0]               show_owner;
    logic                     busy;

    banner_sequencer #(
        .NUM_REQ(NUM_REQ), .MSG_W(MSG_W), .HOLD_CYCLES(HOLD), .GAP_CYCLES(GAP), .CNT_W(4)
    ) dut (
        .clk(clk), .reset(reset), .req(req), .msg_in(msg_in), .pause(pause),
`ifdef BANNER_SKIP_EN
        .skip(skip),
`endif
        .ack(ack), .show(show), .show_msg(show_msg), .show_owner(show_owner), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] owner;
        logic [2:0] msg;
        int         len;
        bit         ackd;
    } exp_t;

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    task automatic push_exp(input logic [1:0] o, input logic [2:0] m, input int l, input bit a);
        exp_t e;
        e.owner = o; e.msg = m; e.len = l; e.ackd = a;
        exp_q.push_back(e);
    endtask

    task automatic set_msg(input int i, input logic [2:0] m);
        msg_in[i*MSG_W +: MSG_W] = m;
    endtask

    task automatic wait_show(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (show) seen = 1'b1;
        end
        if (!seen) check_eq("show_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_ack(input int budget, output logic [NUM_REQ-1:0] a);
        bit seen;
        seen = 1'b0;
        a    = '0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (ack != '0) begin
                seen = 1'b1;
                a    = ack;
            end
        end
        if (!seen) check_eq("ack_timeout", 32'd1, 32'd0);
    endtask

    task automatic wait_idle(input int budget);
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            @(negedge clk);
            if (!busy) seen = 1'b1;
        end
        if (!seen) check_eq("idle_timeout", 32'd1, 32'd0);
    endtask

    // Monitor: measures each visible banner and compares it with the head of the queue when it ends.
    initial begin : monitor
        bit         in_banner;
        logic [1:0] cur_owner;
        logic [2:0] cur_msg;
        int         cur_len;
        exp_t       e;
        in_banner = 1'b0;
        cur_owner = '0;
        cur_msg   = '0;
        cur_len   = 0;
        forever begin
            @(negedge clk);
            if (show && !in_banner) begin
                in_banner = 1'b1;
                cur_owner = show_owner;
                cur_msg   = show_msg;
                cur_len   = 1;
                if (ack != '0) check_eq("stray_ack", 32'(ack), 32'd0);
            end else if (show) begin
                cur_len++;
                check_eq("msg_hold", 32'(show_msg), 32'(cur_msg));
                if (ack != '0) check_eq("stray_ack", 32'(ack), 32'd0);
            end else if (in_banner) begin
                in_banner = 1'b0;
                if (exp_q.size() == 0) begin
                    check_eq("sb_unexpected", 32'd1, 32'd0);
                end else begin
                    e = exp_q.pop_front();
                    check_eq("sb_owner", 32'(cur_owner), 32'(e.owner));
                    check_eq("sb_msg", 32'(cur_msg), 32'(e.msg));
                    check_eq("sb_len", 32'(cur_len), 32'(e.len));
                    check_eq("sb_ack", 32'(ack), e.ackd ? (32'd1 << e.owner) : 32'd0);
                end
                check_eq("msg_zero", 32'(show_msg), 32'd0);
            end else begin
                check_eq("msg_zero", 32'(show_msg), 32'd0);
                if (ack != '0) check_eq("stray_ack", 32'(ack), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : driver
        logic [NUM_REQ-1:0] a;
        reset  = 1'b1;
        req    = '0;
        msg_in = '0;
        pause  = 1'b0;
`ifdef BANNER_SKIP_EN
        skip   = 1'b0;
`endif
        #1;
        check_eq("rst_show", 32'(show), 32'd0);
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_ack", 32'(ack), 32'd0);
        check_eq("rst_owner", 32'(show_owner), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);

        // Test 1: single banner, msg change after grant ignored, gap timing
        req = 4'b0001; set_msg(0, 3'd3);
        push_exp(2'd0, 3'd3, HOLD, 1'b1);
        @(negedge clk);
        check_eq("t1_show", 32'(show), 32'd1);
        check_eq("t1_msg", 32'(show_msg), 32'd3);
        set_msg(0, 3'd5);
        wait_ack(40, a);
        check_eq("t1_ack", 32'(a), 32'b0001);
        req = '0;
        check_eq("t1_busy_gap0", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("t1_ack_pulse", 32'(ack), 32'd0);
        check_eq("t1_busy_gap1", 32'(busy), 32'd1);
        @(negedge clk);
        check_eq("t1_busy_done", 32'(busy), 32'd0);

        // Test 2: round-robin from a freshly reset pointer
        reset = 1'b1; @(negedge clk); reset = 1'b0;
        for (int i = 0; i < 4; i++) set_msg(i, 3'(i + 4));
        for (int i = 0; i < 4; i++) push_exp(2'(i), 3'(i + 4), HOLD, 1'b1);
        req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_ack(60, a);
            check_eq("t2_rr_ack", 32'(a), 32'd1 << i);
            req = req & ~a;
        end
        wait_idle(20);
        push_exp(2'd0, 3'd4, HOLD, 1'b1);
        req = 4'b0001;
        wait_ack(40, a);
        check_eq("t2_again_ack", 32'(a), 32'b0001);
        req = '0;
        wait_idle(20);

        // Test 3: pause freezes the hold counter
        req = 4'b0001; set_msg(0, 3'd2);
        push_exp(2'd0, 3'd2, HOLD + 5, 1'b1);
        wait_show(20);
        @(negedge clk);
        pause = 1'b1;
        repeat (5) @(negedge clk);
        pause = 1'b0;
        wait_ack(40, a);
        check_eq("t3_ack", 32'(a), 32'b0001);
        req = '0;
        wait_idle(20);

        // Test 4: owner 2 aborts, pending owner 3 follows
        set_msg(2, 3'd5); set_msg(3, 3'd6);
        req = 4'b1100;
        push_exp(2'd2, 3'd5, 3, 1'b0);
        push_exp(2'd3, 3'd6, HOLD, 1'b1);
        wait_show(20);
        repeat (2) @(negedge clk);
        req[2] = 1'b0;
        wait_ack(60, a);
        check_eq("t4_ack", 32'(a), 32'b1000);
        req = '0;
        wait_idle(20);

        // Test 5: asynchronous reset mid-banner
        set_msg(1, 3'd1);
        req = 4'b0010;
        push_exp(2'd1, 3'd1, 4, 1'b0);
        wait_show(20);
        repeat (3) @(negedge clk);
        #2;
        reset = 1'b1;
        req   = '0;
        #1;
        check_eq("t5_show", 32'(show), 32'd0);
        check_eq("t5_busy", 32'(busy), 32'd0);
        check_eq("t5_ack", 32'(ack), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        set_msg(2, 3'd3);
        req = 4'b0100;
        push_exp(2'd2, 3'd3, HOLD, 1'b1);
        wait_ack(40, a);
        check_eq("t5_after_ack", 32'(a), 32'b0100);
        req = '0;
        wait_idle(20);

        // Test 6: skip at banner cycle 2 (full hold when the feature is absent)
        set_msg(0, 3'd7);
        req = 4'b0001;
`ifdef BANNER_SKIP_EN
        push_exp(2'd0, 3'd7, 2, 1'b1);
`else
        push_exp(2'd0, 3'd7, HOLD, 1'b1);
`endif
        wait_show(20);
        @(negedge clk);
`ifdef BANNER_SKIP_EN
        skip = 1'b1;
        @(negedge clk);
        skip = 1'b0;
`endif
        wait_ack(40, a);
        check_eq("t6_ack", 32'(a), 32'b0001);
        req = '0;
        wait_idle(20);

        repeat (3) @(negedge clk);
        check_eq("sb_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
